// File: rtl/bulls_cows_engine.sv
// rtl/bulls_cows_engine.sv - Bulls-and-Cows secret generator and serial guess scorer
// Ports: clk, rst_n (synchronous, active-low); gen_enable starts a new game; submit + guess
// request scoring of a guess; secret/secret_valid expose the generated secret; busy is high
// while generating or scoring; result_valid pulses with strike/ball/correct; game_over and
// tries_left track the attempt budget; guess_err pulses when a submitted guess is illegal.
module bulls_cows_engine #(
    parameter int          NUM_DIGITS = 4,
    parameter int          DIGIT_W    = 4,
    parameter int          DIGIT_MAX  = 9,
    parameter int          MAX_TRIES  = 10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         SB_W       = $clog2(NUM_DIGITS + 1),
    localparam int         TR_W       = $clog2(MAX_TRIES + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          gen_enable,
    input  logic                          submit,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] guess,
    output logic [NUM_DIGITS*DIGIT_W-1:0] secret,
    output logic                          secret_valid,
    output logic                          busy,
    output logic                          result_valid,
    output logic [SB_W-1:0]               strike,
    output logic [SB_W-1:0]               ball,
    output logic                          correct,
    output logic                          game_over,
    output logic [TR_W-1:0]               tries_left,
    output logic                          guess_err
);

    generate
        if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
            $error("NUM_DIGITS must be in 2..8");
        end
        if (DIGIT_W > 16) begin : g_bad_digit_w
            $error("DIGIT_W must not exceed the LFSR width");
        end
        if (DIGIT_MAX + 1 < NUM_DIGITS || DIGIT_MAX > (1 << DIGIT_W) - 1) begin : g_bad_digit_max
            $error("DIGIT_MAX incompatible with NUM_DIGITS or DIGIT_W");
        end
        if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_max_tries
            $error("MAX_TRIES must be in 1..255");
        end
        if (LFSR_SEED == 16'h0000) begin : g_bad_seed
            $error("LFSR_SEED must be non-zero");
        end
    endgenerate

    localparam int                IDX_W       = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIGIT_W-1:0] DMAX       = DIGIT_W'(DIGIT_MAX);
    localparam logic [SB_W-1:0]   ALL_STRIKES = SB_W'(NUM_DIGITS);
    localparam logic [TR_W-1:0]   TRIES_INIT  = TR_W'(MAX_TRIES);

    typedef enum logic [2:0] {S_IDLE, S_GEN, S_READY, S_SCORE, S_WIN, S_LOSE} state_t;
    state_t state, state_nxt;

    logic [15:0]        lfsr;
    logic [DIGIT_W-1:0] sec_q    [NUM_DIGITS];
    logic [DIGIT_W-1:0] guess_q  [NUM_DIGITS];
    logic [DIGIT_W-1:0] guess_in [NUM_DIGITS];
    logic [IDX_W-1:0]   slot, idx;
    logic [SB_W-1:0]    s_acc, b_acc, s_sum, b_sum;
    logic [DIGIT_W-1:0] cand, g_cur;
    logic               cand_ok, guess_bad, hit_s, hit_b, last_pos, win, lose;

    assign busy = (state == S_GEN) || (state == S_SCORE);

    always_comb begin
        secret = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            secret[i*DIGIT_W +: DIGIT_W] = sec_q[i];
            guess_in[i]                  = guess[i*DIGIT_W +: DIGIT_W];
        end
    end

    // A candidate is usable if in range and not already present in a filled slot.
    always_comb begin
        cand    = lfsr[DIGIT_W-1:0];
        cand_ok = (cand <= DMAX);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IDX_W'(j) < slot && sec_q[j] == cand) cand_ok = 1'b0;
        end
    end

    always_comb begin
        guess_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (guess_in[i] > DMAX) guess_bad = 1'b1;
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (guess_in[i] == guess_in[j]) guess_bad = 1'b1;
            end
        end
    end

    // Secret digits are unique, so a non-strike digit matches at most one other position.
    always_comb begin
        g_cur = guess_q[idx];
        hit_s = (g_cur == sec_q[idx]);
        hit_b = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (!hit_s && sec_q[j] == g_cur) hit_b = 1'b1;
        end
        s_sum    = s_acc + {{(SB_W-1){1'b0}}, hit_s};
        b_sum    = b_acc + {{(SB_W-1){1'b0}}, hit_b};
        last_pos = (idx == LAST_IDX);
        win      = last_pos && (s_sum == ALL_STRIKES);
        lose     = last_pos && !win && (tries_left == TR_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_GEN:   if (cand_ok && slot == LAST_IDX) state_nxt = S_READY;
            S_READY: if (submit && !guess_bad) state_nxt = S_SCORE;
            S_SCORE: if (last_pos) state_nxt = win ? S_WIN : (lose ? S_LOSE : S_READY);
            default: ;
        endcase
        if (gen_enable) state_nxt = S_GEN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr         <= LFSR_SEED;
            slot         <= '0;
            idx          <= '0;
            s_acc        <= '0;
            b_acc        <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sec_q[i]   <= '0;
                guess_q[i] <= '0;
            end
            secret_valid <= 1'b0;
            result_valid <= 1'b0;
            guess_err    <= 1'b0;
            strike       <= '0;
            ball         <= '0;
            correct      <= 1'b0;
            game_over    <= 1'b0;
            tries_left   <= '0;
        end else begin
            lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            result_valid <= 1'b0;
            guess_err    <= 1'b0;
            if (gen_enable) begin
                secret_valid <= 1'b0;
                strike       <= '0;
                ball         <= '0;
                correct      <= 1'b0;
                game_over    <= 1'b0;
                slot         <= '0;
                tries_left   <= TRIES_INIT;
            end else begin
                case (state)
                    S_GEN: begin
                        if (cand_ok) begin
                            sec_q[slot] <= cand;
                            if (slot == LAST_IDX) secret_valid <= 1'b1;
                            else                  slot         <= slot + 1'b1;
                        end
                    end
                    S_READY: begin
                        if (submit) begin
                            if (guess_bad) begin
                                guess_err <= 1'b1;
                            end else begin
                                for (int i = 0; i < NUM_DIGITS; i++) guess_q[i] <= guess_in[i];
                                s_acc <= '0;
                                b_acc <= '0;
                                idx   <= '0;
                            end
                        end
                    end
                    S_SCORE: begin
                        s_acc <= s_sum;
                        b_acc <= b_sum;
                        idx   <= idx + 1'b1;
                        if (last_pos) begin
                            strike       <= s_sum;
                            ball         <= b_sum;
                            correct      <= win;
                            game_over    <= win || lose;
                            tries_left   <= tries_left - 1'b1;
                            result_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bulls_cows_engine.sv
// tb/tb_bulls_cows_engine.sv - scoreboard bench for bulls_cows_engine (4-digit and 3-digit/3-try instances)
module tb_bulls_cows_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic        rst0_n, gen0, sub0, sv0, busy0, rv0, corr0, go0, err0;
    logic [15:0] guess0, secret0;
    logic [2:0]  strike0, ball0;
    logic [3:0]  tries0;

    logic        rst1_n, gen1, sub1, sv1, busy1, rv1, corr1, go1, err1;
    logic [11:0] guess1, secret1;
    logic [1:0]  strike1, ball1;
    logic [1:0]  tries1;

    bulls_cows_engine u0 (
        .clk(clk), .rst_n(rst0_n), .gen_enable(gen0), .submit(sub0), .guess(guess0),
        .secret(secret0), .secret_valid(sv0), .busy(busy0), .result_valid(rv0),
        .strike(strike0), .ball(ball0), .correct(corr0), .game_over(go0),
        .tries_left(tries0), .guess_err(err0)
    );

    bulls_cows_engine #(.NUM_DIGITS(3), .MAX_TRIES(3)) u1 (
        .clk(clk), .rst_n(rst1_n), .gen_enable(gen1), .submit(sub1), .guess(guess1),
        .secret(secret1), .secret_valid(sv1), .busy(busy1), .result_valid(rv1),
        .strike(strike1), .ball(ball1), .correct(corr1), .game_over(go1),
        .tries_left(tries1), .guess_err(err1)
    );

    typedef struct {
        bit is_err;
        int strike;
        int ball;
        int correct;
        int game_over;
        int tries;
        int due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    logic [15:0] m0, m1;
    always @(posedge clk) m0 <= !rst0_n ? 16'hACE1 : step(m0);
    always @(posedge clk) m1 <= !rst1_n ? 16'hACE1 : step(m1);

    logic [31:0] s0p, s1p;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void predict(input logic [15:0] l0, input int nd,
                                    output logic [31:0] sec, output int cycles);
        logic [15:0] l;
        logic [3:0]  c;
        int          k;
        bit          ok;
        l = l0; k = 0; cycles = 0; sec = '0;
        while (k < nd && cycles < 5000) begin
            c  = l[3:0];
            ok = (c <= 4'd9);
            for (int j = 0; j < k; j++) if (sec[j*4 +: 4] == c) ok = 1'b0;
            if (ok) begin
                sec[k*4 +: 4] = c;
                k++;
            end
            cycles++;
            l = step(l);
        end
    endfunction

    function automatic logic [3:0] absent(input logic [31:0] sec, input int nd, input int which);
        int n;
        bit hit;
        logic [3:0] d4;
        n = 0;
        for (int d = 0; d < 10; d++) begin
            d4  = d[3:0];
            hit = 1'b0;
            for (int j = 0; j < nd; j++) if (sec[j*4 +: 4] == d4) hit = 1'b1;
            if (!hit) begin
                if (n == which) return d4;
                n++;
            end
        end
        return 4'hF;
    endfunction

    task automatic mon(input int u, input int rv, input int er, input int st, input int bl,
                       input int co, input int go, input int tr);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (u == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (u == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
            total++;
            bad++;
            $display("FAIL u%0d_unexpected_pulse: got rv=%0d err=%0d expected no pulse", u, rv, er);
        end else begin
            chk($sformatf("u%0d_err_pulse", u), er, e.is_err);
            chk($sformatf("u%0d_result_pulse", u), rv, !e.is_err);
            chk($sformatf("u%0d_latency_cycle", u), cyc, e.due);
            chk($sformatf("u%0d_strike", u), st, e.strike);
            chk($sformatf("u%0d_ball", u), bl, e.ball);
            chk($sformatf("u%0d_correct", u), co, e.correct);
            chk($sformatf("u%0d_game_over", u), go, e.game_over);
            chk($sformatf("u%0d_tries_left", u), tr, e.tries);
        end
    endtask

    always @(negedge clk) if (rv0 || err0) mon(0, rv0, err0, strike0, ball0, corr0, go0, tries0);
    always @(negedge clk) if (rv1 || err1) mon(1, rv1, err1, strike1, ball1, corr1, go1, tries1);

    task automatic do_gen(input int u);
        logic [15:0] l;
        logic [31:0] sp, so;
        int          ncyc, cnt, nd, mt;
        bit          dropped, ok;
        nd = (u == 0) ? 4 : 3;
        mt = (u == 0) ? 10 : 3;
        if (u == 0) begin gen0 = 1'b1; l = step(m0); end
        else        begin gen1 = 1'b1; l = step(m1); end
        tick(1);
        gen0 = 1'b0;
        gen1 = 1'b0;
        predict(l, nd, sp, ncyc);
        if (u == 0) s0p = sp; else s1p = sp;
        chk($sformatf("u%0d_gen_busy", u), (u == 0) ? busy0 : busy1, 1);
        chk($sformatf("u%0d_gen_tries", u), (u == 0) ? tries0 : tries1, mt);
        chk($sformatf("u%0d_gen_strike", u), (u == 0) ? strike0 : strike1, 0);
        chk($sformatf("u%0d_gen_ball", u), (u == 0) ? ball0 : ball1, 0);
        chk($sformatf("u%0d_gen_game_over", u), (u == 0) ? go0 : go1, 0);
        chk($sformatf("u%0d_gen_secret_valid", u), (u == 0) ? sv0 : sv1, 0);
        cnt = 0;
        dropped = 1'b0;
        while (((u == 0) ? sv0 : sv1) == 1'b0 && cnt < 3000) begin
            if (((u == 0) ? busy0 : busy1) == 1'b0) dropped = 1'b1;
            cnt++;
            tick(1);
        end
        chk($sformatf("u%0d_gen_cycles", u), cnt, ncyc);
        chk($sformatf("u%0d_busy_held_in_gen", u), dropped, 0);
        chk($sformatf("u%0d_ready_busy", u), (u == 0) ? busy0 : busy1, 0);
        so = (u == 0) ? {16'h0, secret0} : {20'h0, secret1};
        chk($sformatf("u%0d_secret", u), so, sp);
        ok = 1'b1;
        for (int i = 0; i < nd; i++) begin
            if (so[i*4 +: 4] > 4'd9) ok = 1'b0;
            for (int j = i + 1; j < nd; j++) if (so[i*4 +: 4] == so[j*4 +: 4]) ok = 1'b0;
        end
        chk($sformatf("u%0d_secret_legal", u), ok, 1);
    endtask

    task automatic sub_go(input int u, input logic [31:0] g, input bit pulse, input bit is_err,
                          input int st, input int bl, input int co, input int go, input int tr);
        exp_t e;
        int   nd;
        nd = (u == 0) ? 4 : 3;
        if (u == 0) begin guess0 = g[15:0]; sub0 = 1'b1; end
        else        begin guess1 = g[11:0]; sub1 = 1'b1; end
        e.is_err    = is_err;
        e.strike    = st;
        e.ball      = bl;
        e.correct   = co;
        e.game_over = go;
        e.tries     = tr;
        e.due       = cyc + 1 + (is_err ? 0 : nd);
        if (pulse) begin
            if (u == 0) q0.push_back(e); else q1.push_back(e);
        end
        tick(1);
        sub0 = 1'b0;
        sub1 = 1'b0;
        guess0 = ~guess0;
        guess1 = ~guess1;
        tick(6);
    endtask

    logic [31:0] s;

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        gen0 = 1'b0; gen1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
        guess0 = '0; guess1 = '0;
        tick(3);
        chk("u0_rst_secret", secret0, 0);
        chk("u0_rst_secret_valid", sv0, 0);
        chk("u0_rst_busy", busy0, 0);
        chk("u0_rst_tries", tries0, 0);
        chk("u0_rst_strike", strike0, 0);
        chk("u0_rst_ball", ball0, 0);
        chk("u0_rst_game_over", go0, 0);
        chk("u0_rst_correct", corr0, 0);
        chk("u1_rst_tries", tries1, 0);
        chk("u1_rst_secret_valid", sv1, 0);
        rst0_n = 1'b1; rst1_n = 1'b1;
        tick(2);

        do_gen(0);
        s = s0p;
        sub_go(0, s, 1, 0, 4, 0, 1, 1, 9);
        chk("u0_win_busy", busy0, 0);
        chk("u0_win_game_over", go0, 1);
        chk("u0_win_correct", corr0, 1);
        sub_go(0, {16'h0, s[3:0], s[15:12], s[11:8], s[7:4]}, 0, 0, 0, 0, 0, 0, 0);
        chk("u0_after_win_strike", strike0, 4);
        chk("u0_after_win_tries", tries0, 9);
        chk("u0_after_win_game_over", go0, 1);

        do_gen(0);
        s = s0p;
        sub_go(0, {16'h0, s[3:0], s[15:12], s[11:8], s[7:4]}, 1, 0, 0, 4, 0, 0, 9);
        sub_go(0, {16'h0, absent(s, 4, 1), absent(s, 4, 0), s[7:4], s[3:0]}, 1, 0, 2, 0, 0, 0, 8);
        chk("u0_ready_busy_after_score", busy0, 0);
        chk("u0_ready_game_over", go0, 0);
        sub_go(0, 32'h0000_3211, 1, 1, 2, 0, 0, 0, 8);
        sub_go(0, {16'h0, 4'hA, s[11:8], s[7:4], s[3:0]}, 1, 1, 2, 0, 0, 0, 8);
        sub_go(0, {16'h0, s[11:8], s[15:12], s[7:4], s[3:0]}, 1, 0, 2, 2, 0, 0, 7);

        guess0 = {s[3:0], s[15:12], s[11:8], s[7:4]};
        sub0 = 1'b1;
        tick(1);
        sub0 = 1'b0;
        tick(1);
        do_gen(0);

        gen0 = 1'b1;
        tick(1);
        gen0 = 1'b0;
        rst0_n = 1'b0;
        tick(1);
        rst0_n = 1'b1;
        chk("u0_midgen_rst_secret", secret0, 0);
        chk("u0_midgen_rst_secret_valid", sv0, 0);
        chk("u0_midgen_rst_busy", busy0, 0);
        chk("u0_midgen_rst_tries", tries0, 0);
        chk("u0_midgen_rst_result_valid", rv0, 0);
        tick(20);
        chk("u0_idle_secret_valid", sv0, 0);
        chk("u0_idle_busy", busy0, 0);

        do_gen(1);
        s = s1p;
        sub_go(1, {20'h0, s[3:0], s[11:8], s[7:4]}, 1, 0, 0, 3, 0, 0, 2);
        sub_go(1, {20'h0, s[7:4], s[11:8], s[3:0]}, 1, 0, 1, 2, 0, 0, 1);
        sub_go(1, {20'h0, absent(s, 3, 2), absent(s, 3, 1), absent(s, 3, 0)}, 1, 0, 0, 0, 0, 1, 0);
        chk("u1_lose_busy", busy1, 0);
        chk("u1_lose_game_over", go1, 1);
        chk("u1_lose_correct", corr1, 0);
        sub_go(1, s, 0, 0, 0, 0, 0, 0, 0);
        chk("u1_after_lose_tries", tries1, 0);
        chk("u1_after_lose_game_over", go1, 1);
        chk("u1_after_lose_strike", strike1, 0);
        do_gen(1);

        tick(5);
        chk("u0_scoreboard_drained", q0.size(), 0);
        chk("u1_scoreboard_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
